// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC instruction fetch with a DEPTH-entry {pc, ir} output FIFO and redirect flush.
// Optional FETCH_QUEUE_STAT_EN adds STAT_FETCHED (pops) and STAT_STALL (ready-but-empty cycles).
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT_PC,
  output logic [31:0] OUT_IR
`ifdef FETCH_QUEUE_STAT_EN
  ,
  output logic [31:0] STAT_FETCHED,
  output logic [31:0] STAT_STALL
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc;
  logic          pend;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];

  logic [SW-1:0] credit_c;
  logic          push_c;
  logic          pop_c;

  // Credits count buffered plus in-flight words; the same-cycle pop is deliberately ignored.
  always_comb begin
    credit_c  = SW'(count) + SW'(pend);
    IMEM_REQ  = !RST && !REDIRECT && (credit_c < SW'(DEPTH));
    OUT_VALID = (count != '0) && !REDIRECT;
    push_c    = pend && !REDIRECT;
    pop_c     = OUT_VALID && OUT_READY;
    OUT_PC    = OUT_VALID ? pc_mem[rd_ptr] : 32'h0;
    OUT_IR    = OUT_VALID ? ir_mem[rd_ptr] : 32'h0;
  end

  assign IMEM_ADDR = fetch_pc;

  // Fetch PC, in-flight tracking and FIFO bookkeeping; redirect overrides everything else.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc <= RESET_PC & WORD_MASK;
      pend_pc  <= 32'h0;
      pend     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (REDIRECT) begin
      fetch_pc <= REDIRECT_PC & WORD_MASK;
      pend     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pend <= IMEM_REQ;
      if (IMEM_REQ) begin
        pend_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c && !pop_c)      count <= count + CW'(1);
      else if (!push_c && pop_c) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge CLK) begin
    if (push_c) begin
      pc_mem[wr_ptr] <= pend_pc;
      ir_mem[wr_ptr] <= IMEM_DATA;
    end
  end

  a_no_push_when_full : assert property (@(posedge CLK) disable iff (RST)
    !(push_c && (count == CW'(DEPTH))));

`ifdef FETCH_QUEUE_STAT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STAT_FETCHED <= 32'h0;
      STAT_STALL   <= 32'h0;
    end else begin
      if (pop_c) STAT_FETCHED <= STAT_FETCHED + 32'd1;
      if (OUT_READY && !OUT_VALID && !REDIRECT) STAT_STALL <= STAT_STALL + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus directed scenarios and random traffic.
// Builds with or without FETCH_QUEUE_STAT_EN.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_PC;
  logic [31:0] OUT_IR;
`ifdef FETCH_QUEUE_STAT_EN
  logic [31:0] STAT_FETCHED;
  logic [31:0] STAT_STALL;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_DATA   (IMEM_DATA),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_PC      (OUT_PC),
    .OUT_IR      (OUT_IR)
`ifdef FETCH_QUEUE_STAT_EN
    ,
    .STAT_FETCHED(STAT_FETCHED),
    .STAT_STALL  (STAT_STALL)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: buffered entries, words in flight, next fetch address.
  logic [31:0] m_pc[$];
  logic [31:0] m_ir[$];
  logic [31:0] m_infl[$];
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_fetched = 32'h0;
  logic [31:0] m_stall = 32'h0;

  // Observation logs for directed scenarios.
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ir[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          req_cnt = 0;
  int          first_req = -1;
  int          first_val = -1;
  logic        last_valid = 1'b0;
  logic [31:0] last_pc = 32'h0;
  logic        req_s = 1'b0;
  logic [31:0] addr_s = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] pc);
    return 32'h1000 + (pc >> 2);
  endfunction

  function automatic logic [31:0] pp(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc.delete(); m_ir.delete(); m_infl.delete();
    m_fpc = 32'h0; m_fetched = 32'h0; m_stall = 32'h0;
  endtask

  task automatic compare_outputs();
    logic        exp_req;
    logic        exp_val;
    exp_req = !RST && !REDIRECT && (m_pc.size() + m_infl.size() < DEPTH);
    exp_val = !RST && !REDIRECT && (m_pc.size() != 0);
    chk("imem_req", 32'(IMEM_REQ), 32'(exp_req));
    chk("out_valid", 32'(OUT_VALID), 32'(exp_val));
    chk("out_pc", OUT_PC, exp_val ? m_pc[0] : 32'h0);
    chk("out_ir", OUT_IR, exp_val ? m_ir[0] : 32'h0);
    if (exp_req) chk("imem_addr", IMEM_ADDR, m_fpc);
`ifdef FETCH_QUEUE_STAT_EN
    chk("stat_fetched", STAT_FETCHED, RST ? 32'h0 : m_fetched);
    chk("stat_stall", STAT_STALL, RST ? 32'h0 : m_stall);
`endif
  endtask

  // Advance the model across one clock edge from the inputs of the ending cycle.
  task automatic model_update();
    logic        req;
    logic [31:0] p;
    if (RST) begin
      model_reset();
    end else if (REDIRECT) begin
      m_pc.delete(); m_ir.delete(); m_infl.delete();
      m_fpc = REDIRECT_PC & 32'hFFFF_FFFC;
    end else begin
      req = (m_pc.size() + m_infl.size()) < DEPTH;
      if (OUT_READY && m_pc.size() == 0) m_stall++;
      if (OUT_READY && m_pc.size() != 0) begin
        void'(m_pc.pop_front());
        void'(m_ir.pop_front());
        m_fetched++;
      end
      if (m_infl.size() != 0) begin
        p = m_infl.pop_front();
        m_pc.push_back(p);
        m_ir.push_back(word(p));
      end
      if (req) begin
        m_infl.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic log_cycle();
    if (IMEM_REQ) begin
      req_cnt++;
      if (first_req < 0) first_req = cyc;
    end
    if (OUT_VALID && first_val < 0) first_val = cyc;
    if (OUT_VALID && OUT_READY) begin
      pop_pc.push_back(OUT_PC);
      pop_ir.push_back(OUT_IR);
      pop_cyc.push_back(cyc);
    end
    last_valid = OUT_VALID;
    last_pc    = OUT_PC;
  endtask

  task automatic clear_logs();
    pop_pc.delete(); pop_ir.delete(); pop_cyc.delete();
    req_cnt = 0; first_req = -1; first_val = -1;
  endtask

  // One cycle: drive after negedge, compare, cross the posedge, then return the memory word.
  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge CLK);
    RST = rst; OUT_READY = rdy; REDIRECT = redir; REDIRECT_PC = rpc;
    #1;
    compare_outputs();
    log_cycle();
    req_s  = IMEM_REQ;
    addr_s = IMEM_ADDR;
    @(posedge CLK);
    model_update();
    #1;
    IMEM_DATA = req_s ? word(addr_s) : $urandom();
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int n;
    RST = 1'b1; OUT_READY = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; IMEM_DATA = 32'h0;

    // Streaming from reset with decode always ready.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    clear_logs();
    repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("s1_latency", 32'(first_val - first_req), 32'd2);
    chk("s1_pc0", pp(0), 32'h0);
    chk("s1_ir0", (pop_ir.size() > 0) ? pop_ir[0] : 32'hBAD0_BAD0, 32'h1000);
    chk("s1_pc1", pp(1), 32'h4);
    chk("s1_pc2", pp(2), 32'h8);
    chk("s1_pc3", pp(3), 32'hC);
    chk("s1_no_bubble", (pop_cyc.size() > 3) ? 32'(pop_cyc[3] - pop_cyc[0]) : 32'hFFFF, 32'd3);

    // Backpressure fills the queue, then drains in order.
    do_reset();
    clear_logs();
    repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("s2_req_count", 32'(req_cnt), 32'd4);
    chk("s2_head_held", last_pc, 32'h0);
    chk("s2_no_pop", 32'(pop_pc.size()), 32'd0);
    clear_logs();
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("s2_pc0", pp(0), 32'h0);
    chk("s2_pc1", pp(1), 32'h4);
    chk("s2_pc2", pp(2), 32'h8);
    chk("s2_pc3", pp(3), 32'hC);
    chk("s2_pc4", pp(4), 32'h10);
    chk("s2_no_bubble", (pop_cyc.size() > 4) ? 32'(pop_cyc[4] - pop_cyc[0]) : 32'hFFFF, 32'd4);

    // Redirect with entries buffered and a response in flight.
    do_reset();
    repeat (10) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    clear_logs();
    step(1'b0, 1'b1, 1'b1, 32'h203);
    chk("s3_valid_in_redirect", 32'(last_valid), 32'd0);
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("s3_pc0", pp(0), 32'h200);
    chk("s3_ir0", (pop_ir.size() > 0) ? pop_ir[0] : 32'hBAD0_BAD0, 32'h1080);
    chk("s3_pc1", pp(1), 32'h204);
    n = 0;
    foreach (pop_pc[i]) if (pop_pc[i] >= 32'h8 && pop_pc[i] <= 32'h18) n++;
    chk("s3_no_stale", 32'(n), 32'd0);

    // Redirect near the top of the address space wraps to zero.
    clear_logs();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (7) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("s4_pc0", pp(0), 32'hFFFF_FFF8);
    chk("s4_pc1", pp(1), 32'hFFFF_FFFC);
    chk("s4_pc2", pp(2), 32'h0);
    chk("s4_pc3", pp(3), 32'h4);

    // Asynchronous reset in the middle of a cycle with three entries buffered.
    do_reset();
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    OUT_READY = 1'b0; REDIRECT = 1'b0;
    #1;
    compare_outputs();
    chk("s5_valid_before", 32'(OUT_VALID), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("s5_valid_async", 32'(OUT_VALID), 32'd0);
    chk("s5_req_async", 32'(IMEM_REQ), 32'd0);
    chk("s5_pc_async", OUT_PC, 32'h0);
    @(posedge CLK);
    model_reset();
    #1;
    IMEM_DATA = $urandom();
    cyc++;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    clear_logs();
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("s5_pc0", pp(0), 32'h0);
    chk("s5_ir0", (pop_ir.size() > 0) ? pop_ir[0] : 32'hBAD0_BAD0, 32'h1000);
    chk("s5_pc1", pp(1), 32'h4);

`ifdef FETCH_QUEUE_STAT_EN
    // Five pops and three ready-but-empty cycles.
    do_reset();
    repeat (7) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("s6_fetched", STAT_FETCHED, 32'd5);
    chk("s6_stall", STAT_STALL, 32'd3);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_rdy;
      logic        r_red;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 199) == 0);
      r_red = ($urandom_range(0, 15) == 0);
      r_rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom();
      step(r_rst, r_rdy, r_red, r_pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
